// File: rtl/memory_be_pipe.sv
// Single-port scratchpad with byte enables, valid/ready requests,
// a 1..4 stage read pipeline, error responses and a post-reset clear.
module memory_be_pipe #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_SIZE    = 16,
  parameter int RD_LATENCY  = 1,
  parameter int RESET_CLEAR = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    wr,
  input  logic                    rd,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic                    wr_resp,
  output logic                    wr_err,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rd_err
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int CW = $clog2(MEM_SIZE + 1);
  localparam logic [ADDR_WIDTH:0] LP_SIZE =
    (ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [CW-1:0] LP_LAST = CW'(MEM_SIZE - 1);

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_ready;
  logic                  r_wresp;
  logic                  r_werr;
  logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];
  logic                  r_pv  [RD_LATENCY];
  logic [DATA_WIDTH-1:0] r_pd  [RD_LATENCY];
  logic                  r_pe  [RD_LATENCY];

  logic                  w_acc;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_ill;
  logic                  w_inr;
  logic [IW-1:0]         w_idx;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_acc   = req_valid & r_ready;
  assign w_wr    = w_acc & wr & ~rd;
  assign w_rd    = w_acc & rd & ~wr;
  assign w_ill   = w_acc & wr & rd;
  assign w_inr   = {1'b0, addr} < LP_SIZE;
  assign w_idx   = addr[IW-1:0];
  assign w_rdata = w_inr ? r_mem[w_idx] : '0;

  // Control FSM: clear sequencing, ready and write responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= (RESET_CLEAR != 0) ? ST_INIT : ST_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_wresp <= 1'b0;
      r_werr  <= 1'b0;
    end else begin
      r_wresp <= w_wr | w_ill;
      r_werr  <= w_ill | (w_wr & ~w_inr);
      unique case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LP_LAST) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
        end
        ST_IDLE: r_ready <= 1'b1;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Storage: clear engine writes word r_cnt, else byte-masked writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == ST_INIT) begin
        r_mem[r_cnt[IW-1:0]] <= '0;
      end else if (w_wr && w_inr) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) begin
            r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
    end
  end

  // Read pipeline: data sampled at accept, shifted RD_LATENCY-1 times.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= '0;
        r_pe[i] <= 1'b0;
      end
    end else begin
      r_pv[0] <= w_rd;
      r_pd[0] <= w_rd ? w_rdata : '0;
      r_pe[0] <= w_rd & ~w_inr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pd[i] <= r_pd[i-1];
        r_pe[i] <= r_pe[i-1];
      end
    end
  end

  assign req_ready = r_ready;
  assign wr_resp   = r_wresp;
  assign wr_err    = r_werr;
  assign rd_valid  = r_pv[RD_LATENCY-1];
  assign rdata     = r_pd[RD_LATENCY-1];
  assign rd_err    = r_pe[RD_LATENCY-1];

endmodule

// File: tb/tb_memory_be_pipe.sv
// Bench for memory_be_pipe: cycle-level reference model on one
// clearing instance, directed retention check on a second one.
module tb_memory_be_pipe;

  localparam int AW = 5;
  localparam int MS = 20;
  localparam int RL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        wr;
  logic        rd;
  logic [AW-1:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        wr_resp;
  logic        wr_err;
  logic        rd_valid;
  logic [31:0] rdata;
  logic        rd_err;

  memory_be_pipe #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(32), .MEM_SIZE(MS),
    .RD_LATENCY(RL), .RESET_CLEAR(1)
  ) u_a (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_ready(req_ready), .wr(wr), .rd(rd), .addr(addr),
    .wdata(wdata), .be(be), .wr_resp(wr_resp), .wr_err(wr_err),
    .rd_valid(rd_valid), .rdata(rdata), .rd_err(rd_err)
  );

  logic        rb;
  logic        vb;
  logic        rdyb;
  logic        wrb;
  logic        rdb;
  logic [3:0]  addrb;
  logic [31:0] wdb;
  logic [3:0]  beb;
  logic        wrespb;
  logic        werrb;
  logic        rvb;
  logic [31:0] rdatab;
  logic        rerrb;

  memory_be_pipe #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .MEM_SIZE(16),
    .RD_LATENCY(4), .RESET_CLEAR(0)
  ) u_b (
    .clk(clk), .reset(rb), .req_valid(vb),
    .req_ready(rdyb), .wr(wrb), .rd(rdb), .addr(addrb),
    .wdata(wdb), .be(beb), .wr_resp(wrespb), .wr_err(werrb),
    .rd_valid(rvb), .rdata(rdatab), .rd_err(rerrb)
  );

  int nassert = 0;
  int nfail   = 0;
  int cyc     = 0;

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } rq_t;

  logic [31:0] m [MS];
  rq_t         q [$];
  int          wr_due = -1;
  logic        wr_e = 1'b0;
  logic        mready = 1'b0;
  int          init_left = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of instance A: model the edge, then compare outputs.
  task automatic step();
    logic        acc;
    int          ai;
    logic [31:0] mask;
    logic [31:0] rv;
    rq_t         r;
    @(posedge clk);
    cyc++;
    acc = req_valid && mready && !reset;
    ai  = int'(addr);
    if (reset) begin
      mready = 1'b0;
      q.delete();
      wr_due = -1;
      init_left = MS;
      for (int k = 0; k < MS; k++) m[k] = '0;
    end else begin
      if (init_left > 0) init_left--;
      mready = (init_left == 0);
      if (acc && wr && rd) begin
        wr_due = cyc;
        wr_e = 1'b1;
      end else if (acc && wr) begin
        wr_due = cyc;
        wr_e = (ai >= MS);
        if (ai < MS) begin
          mask = '0;
          for (int b = 0; b < 4; b++)
            if (be[b]) mask = mask | (32'hFF << (8 * b));
          m[ai] = (m[ai] & ~mask) | (wdata & mask);
        end
      end else if (acc && rd) begin
        r.due = cyc + RL - 1;
        r.d = (ai < MS) ? m[ai] : 32'h0;
        r.e = (ai >= MS);
        q.push_back(r);
      end
    end
    #1;
    chk("ready", 32'(req_ready), 32'(mready));
    chk("wr_resp", 32'(wr_resp), 32'(wr_due == cyc));
    if (wr_due == cyc) chk("wr_err", 32'(wr_err), 32'(wr_e));
    rv = 32'(q.size() > 0 && q[0].due == cyc);
    chk("rd_valid", 32'(rd_valid), rv);
    if (rv != 0) begin
      chk("rdata", rdata, q[0].d);
      chk("rd_err", 32'(rd_err), 32'(q[0].e));
      void'(q.pop_front());
    end else begin
      chk("rdata_idle", rdata, 32'h0);
    end
  endtask

  task automatic req(bit w, bit r, int a,
                     logic [31:0] d, logic [3:0] b);
    req_valid = 1'b1;
    wr = w;
    rd = r;
    addr = AW'(a);
    wdata = d;
    be = b;
    step();
  endtask

  task automatic idle(int n);
    req_valid = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_init(string tag);
    int low;
    low = 0;
    reset = 1'b0;
    while (req_ready !== 1'b1 && low < 60) begin
      low++;
      step();
    end
    chk(tag, 32'(low), 32'(MS));
  endtask

  task automatic tick_b();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    req_valid = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    addr = '0;
    wdata = '0;
    be = '0;
    rb = 1'b1;
    vb = 1'b0;
    wrb = 1'b0;
    rdb = 1'b0;
    addrb = '0;
    wdb = '0;
    beb = '0;

    step();
    step();
    wait_init("init_len");

    for (int a = 0; a < MS; a++) req(0, 1, a, 0, 0);
    idle(4);

    req(1, 0, 3, 32'h0000_0050, 4'hF);
    req(0, 1, 3, 0, 0);
    idle(4);

    req(1, 0, 5, 32'hAABB_CCDD, 4'hF);
    req(1, 0, 5, 32'h1122_3344, 4'b0101);
    req(0, 1, 5, 0, 0);
    idle(4);

    req(1, 0, 25, 32'hDEAD_BEEF, 4'hF);
    req(0, 1, 25, 0, 0);
    idle(4);

    req(1, 1, 7, 32'h5A5A_5A5A, 4'hF);
    idle(2);
    for (int a = 0; a < MS; a++) req(0, 1, a, 0, 0);
    idle(4);

    req(0, 0, 9, 32'hFFFF_FFFF, 4'hF);
    req(1, 0, 9, 32'h0000_0000, 4'h0);
    req(0, 1, 9, 0, 0);
    idle(4);

    for (int k = 0; k < 300; k++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      addr = AW'($urandom_range(0, 31));
      wdata = $urandom;
      be = 4'($urandom);
      step();
    end
    idle(4);
    for (int a = 0; a < MS; a++) req(0, 1, a, 0, 0);
    idle(4);

    req(0, 1, 1, 0, 0);
    req(0, 1, 2, 0, 0);
    req_valid = 1'b0;
    rd = 1'b0;
    reset = 1'b1;
    step();
    wait_init("init_len2");
    req(0, 1, 3, 0, 0);
    req(0, 1, 5, 0, 0);
    idle(4);

    rb = 1'b0;
    seen = 0;
    while (rdyb !== 1'b1 && seen < 10) begin
      seen++;
      tick_b();
    end
    chk("b_ready", 32'(rdyb), 32'h1);
    vb = 1'b1;
    wrb = 1'b1;
    beb = 4'hF;
    addrb = 4'd2;
    wdb = 32'hCAFE_F00D;
    tick_b();
    addrb = 4'd7;
    wdb = 32'h0123_4567;
    tick_b();
    wrb = 1'b0;
    rdb = 1'b1;
    addrb = 4'd2;
    tick_b();
    addrb = 4'd7;
    tick_b();
    vb = 1'b0;
    rdb = 1'b0;
    rb = 1'b1;
    tick_b();
    chk("b_rst_ready", 32'(rdyb), 32'h0);
    rb = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (rvb === 1'b1) seen++;
      tick_b();
    end
    chk("b_flush", 32'(seen), 32'h0);
    seen = 0;
    while (rdyb !== 1'b1 && seen < 10) begin
      seen++;
      tick_b();
    end
    chk("b_ready2", 32'(rdyb), 32'h1);
    vb = 1'b1;
    rdb = 1'b1;
    addrb = 4'd2;
    tick_b();
    addrb = 4'd7;
    tick_b();
    vb = 1'b0;
    rdb = 1'b0;
    tick_b();
    chk("b_lat_early", 32'(rvb), 32'h0);
    tick_b();
    chk("b_rv0", 32'(rvb), 32'h1);
    chk("b_keep2", rdatab, 32'hCAFE_F00D);
    tick_b();
    chk("b_rv1", 32'(rvb), 32'h1);
    chk("b_keep7", rdatab, 32'h0123_4567);
    chk("b_err", 32'(rerrb), 32'h0);
    tick_b();
    chk("b_rv_end", 32'(rvb), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule
